// File: rtl/matrix_rd_seq.sv
// Matrix read sequencer: walks (row, col) of a latched matrix, issues linear memory reads,
// and re-tags in-order responses as an element stream. Define MATRIX_RD_SEQ_COL_MAJOR_EN for column-major order.
module matrix_rd_seq #(
    parameter int MSB = 11,
    parameter int DW  = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [MSB:0]  row_max,
    input  logic [MSB:0]  col_max,
    output logic          busy,
    output logic          done,
    output logic          req_valid,
    input  logic          req_ready,
    output logic [MSB:0]  req_addr,
    input  logic          rsp_valid,
    input  logic [DW-1:0] rsp_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [MSB:0]  out_row,
    output logic [MSB:0]  out_col,
    output logic          out_last,
    output logic          rsp_err
);

    localparam int KW = $clog2(MSB + 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_nx;
    logic [MSB:0]  row_max_q, col_max_q, cur_row, cur_col;
    logic [KW-1:0] shift_q, shift_d;
    logic [2:0]    meta_cnt, data_cnt;
    logic [1:0]    meta_wr, meta_rd, data_wr, data_rd;
    logic [MSB:0]  meta_row  [4];
    logic [MSB:0]  meta_col  [4];
    logic          meta_last [4];
    logic [DW-1:0] data_mem  [4];
    logic          start_acc, req_hs, out_hs, rsp_acc, rsp_drop, cur_last;

    // Column width in address bits = number of trailing ones in col_max (lowest zero wins).
    always_comb begin
        shift_d = KW'(MSB + 1);
        for (int i = MSB; i >= 0; i--) begin
            if (!col_max[i]) shift_d = KW'(i);
        end
    end

    assign start_acc = (state == IDLE) && start;
    assign req_valid = (state == RUN) && (meta_cnt < 3'd4);
    assign req_hs    = req_valid && req_ready;
    assign out_valid = (data_cnt != 3'd0);
    assign out_hs    = out_valid && out_ready;
    // A beat is only legal while some request still lacks its data.
    assign rsp_acc   = rsp_valid && (data_cnt != meta_cnt);
    assign rsp_drop  = rsp_valid && !rsp_acc;
    assign cur_last  = (cur_row == row_max_q) && (cur_col == col_max_q);
    assign req_addr  = (cur_row << shift_q) | cur_col;

    assign out_data  = out_valid ? data_mem[data_rd]  : '0;
    assign out_row   = out_valid ? meta_row[meta_rd]  : '0;
    assign out_col   = out_valid ? meta_col[meta_rd]  : '0;
    assign out_last  = out_valid ? meta_last[meta_rd] : 1'b0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (req_hs && cur_last) state_nx = DRAIN;
            DRAIN:   if (out_hs && out_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_max_q <= '0;
            col_max_q <= '0;
            shift_q   <= '0;
            cur_row   <= '0;
            cur_col   <= '0;
            meta_cnt  <= '0;
            data_cnt  <= '0;
            meta_wr   <= '0;
            meta_rd   <= '0;
            data_wr   <= '0;
            data_rd   <= '0;
            done      <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            done <= (state == DRAIN) && out_hs && out_last;

            if (start_acc) begin
                row_max_q <= row_max;
                col_max_q <= col_max;
                shift_q   <= shift_d;
                cur_row   <= '0;
                cur_col   <= '0;
                rsp_err   <= 1'b0;
            end else if (req_hs) begin
`ifdef MATRIX_RD_SEQ_COL_MAJOR_EN
                if (cur_row == row_max_q) begin
                    cur_row <= '0;
                    cur_col <= cur_col + 1'b1;
                end else begin
                    cur_row <= cur_row + 1'b1;
                end
`else
                if (cur_col == col_max_q) begin
                    cur_col <= '0;
                    cur_row <= cur_row + 1'b1;
                end else begin
                    cur_col <= cur_col + 1'b1;
                end
`endif
            end

            if (rsp_drop) rsp_err <= 1'b1;

            if (req_hs)  meta_wr <= meta_wr + 1'b1;
            if (rsp_acc) data_wr <= data_wr + 1'b1;
            if (out_hs) begin
                meta_rd <= meta_rd + 1'b1;
                data_rd <= data_rd + 1'b1;
            end
            meta_cnt <= meta_cnt + 3'(req_hs)  - 3'(out_hs);
            data_cnt <= data_cnt + 3'(rsp_acc) - 3'(out_hs);
        end
    end

    // NOTE: FIFO storage has no reset; validity lives in the counts, and outputs are gated by out_valid.
    always_ff @(posedge CLK) begin
        if (req_hs) begin
            meta_row[meta_wr]  <= cur_row;
            meta_col[meta_wr]  <= cur_col;
            meta_last[meta_wr] <= cur_last;
        end
        if (rsp_acc) data_mem[data_wr] <= rsp_data;
    end

endmodule

// File: tb/tb_matrix_rd_seq.sv
// Directed bench for matrix_rd_seq: table of matrix reads with a latency-1 memory model,
// plus hand-written reset and error sequences. Honours MATRIX_RD_SEQ_COL_MAJOR_EN for expected order.
module tb_matrix_rd_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [11:0] row_max, col_max;
    logic        busy, done, req_valid, req_ready;
    logic [11:0] req_addr;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic [11:0] out_row, out_col;
    logic        out_last, rsp_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          rmax;
        int          cmax;
        int          mode;      // 1: out_ready held low for the first 12 cycles
        bit          poke;      // pulse start (row_max=7) while running
        int          exp_cnt;
        logic [11:0] exp_last;
    } vec_t;

    matrix_rd_seq dut (
        .CLK(CLK), .RST(RST), .start(start), .row_max(row_max), .col_max(col_max),
        .busy(busy), .done(done), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .rsp_err(rsp_err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] mem_f(input logic [11:0] a);
        return (16'(a) * 16'd7) + 16'h1234;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic run_read(input vec_t v);
        int          er[$];
        int          ec[$];
        logic [11:0] pend[$];
        int          nreq = 0, nout = 0;
        int          last_req_cyc = -1, last_out_cyc = -1, last_hs_cyc = -1, done_cyc = -1;
        logic [11:0] last_addr = '0;
        logic [11:0] ea;
`ifdef MATRIX_RD_SEQ_COL_MAJOR_EN
        for (int c = 0; c <= v.cmax; c++)
            for (int r = 0; r <= v.rmax; r++) begin er.push_back(r); ec.push_back(c); end
`else
        for (int r = 0; r <= v.rmax; r++)
            for (int c = 0; c <= v.cmax; c++) begin er.push_back(r); ec.push_back(c); end
`endif
        row_max = 12'(v.rmax);
        col_max = 12'(v.cmax);
        req_ready = 1'b1;
        out_ready = 1'b1;
        rsp_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_cleared_by_start", rsp_err, 0);

        for (int cyc = 0; cyc < 600 && done_cyc < 0; cyc++) begin
            if (pend.size() > 0) begin
                rsp_valid = 1'b1;
                rsp_data  = mem_f(pend.pop_front());
            end else begin
                rsp_valid = 1'b0;
                rsp_data  = '0;
            end
            out_ready = !(v.mode == 1 && cyc < 12);
            start = v.poke && (cyc == 3);
            if (start) row_max = 12'd7;
            #1;
            if (done) begin
                done_cyc = cyc;
            end else begin
                if (req_valid && req_ready) begin
                    if (nreq < er.size()) begin
                        ea = 12'(er[nreq] * (v.cmax + 1) + ec[nreq]);
                        check("req_addr", req_addr, ea);
                    end else begin
                        check("req_count_overrun", nreq + 1, er.size());
                    end
                    if (v.mode == 0 && nreq > 0) check("req_gap", cyc - last_req_cyc, 1);
                    last_req_cyc = cyc;
                    last_addr = req_addr;
                    pend.push_back(req_addr);
                    nreq++;
                end
                if (out_valid && out_ready) begin
                    if (nout < er.size()) begin
                        ea = 12'(er[nout] * (v.cmax + 1) + ec[nout]);
                        check("out_data", out_data, mem_f(ea));
                        check("out_row", out_row, er[nout]);
                        check("out_col", out_col, ec[nout]);
                        check("out_last", out_last, (nout == er.size() - 1));
                    end else begin
                        check("out_count_overrun", nout + 1, er.size());
                    end
                    if (v.mode == 0 && nout > 0) check("out_gap", cyc - last_out_cyc, 1);
                    if (out_last) last_hs_cyc = cyc;
                    last_out_cyc = cyc;
                    nout++;
                end
                if (v.mode == 1 && cyc == 11) begin
                    check("reqs_while_stalled", nreq, 4);
                    check("req_valid_stalled", req_valid, 0);
                end
            end
            tick();
        end
        start = 1'b0;
        rsp_valid = 1'b0;
        out_ready = 1'b1;
        check("done_seen", (done_cyc >= 0), 1);
        check("done_latency", done_cyc - last_hs_cyc, 1);
        check("n_req", nreq, v.exp_cnt);
        check("n_out", nout, v.exp_cnt);
        check("final_addr", last_addr, v.exp_last);
        check("busy_at_done", busy, 0);
        tick();
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        check("rsp_err_clean", rsp_err, 0);
    endtask

    vec_t        vecs[6];
    logic [11:0] pend_r[$];

    initial begin
        vecs[0] = '{rmax: 1, cmax: 3, mode: 0, poke: 1'b0, exp_cnt: 8, exp_last: 12'd7};
        vecs[1] = '{rmax: 1, cmax: 3, mode: 1, poke: 1'b0, exp_cnt: 8, exp_last: 12'd7};
        vecs[2] = '{rmax: 1, cmax: 3, mode: 0, poke: 1'b1, exp_cnt: 8, exp_last: 12'd7};
        vecs[3] = '{rmax: 0, cmax: 0, mode: 0, poke: 1'b0, exp_cnt: 1, exp_last: 12'd0};
        vecs[4] = '{rmax: 2, cmax: 1, mode: 0, poke: 1'b0, exp_cnt: 6, exp_last: 12'd5};
        vecs[5] = '{rmax: 0, cmax: 7, mode: 1, poke: 1'b0, exp_cnt: 8, exp_last: 12'd7};

        RST = 1'b1;
        start = 1'b0;
        row_max = '0;
        col_max = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_req_addr", req_addr, 0);
        RST = 1'b0;
        tick();

        foreach (vecs[i]) run_read(vecs[i]);

        // Reset mid-read: three requests out, one answered, two still pending.
        row_max = 12'd1;
        col_max = 12'd3;
        req_ready = 1'b1;
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            if (cyc == 1) begin
                rsp_valid = 1'b1;
                rsp_data = mem_f(pend_r.pop_front());
            end else begin
                rsp_valid = 1'b0;
            end
            #1;
            check("mid_req_valid", req_valid, 1);
            pend_r.push_back(req_addr);
            tick();
        end
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        #1;
        check("pre_rst_out_valid", out_valid, 1);
        check("pre_rst_out_data", out_data, mem_f(12'd0));
        RST = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_req_valid", req_valid, 0);
        check("arst_req_addr", req_addr, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_row", out_row, 0);
        check("arst_out_col", out_col, 0);
        check("arst_out_last", out_last, 0);
        tick();
        RST = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            rsp_valid = 1'b1;
            rsp_data = mem_f(pend_r.pop_front());
            tick();
        end
        rsp_valid = 1'b0;
        check("late_rsp_err", rsp_err, 1);
        check("late_rsp_dropped", out_valid, 0);
        check("late_rsp_idle", busy, 0);

        run_read(vecs[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
